// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle MUL / DIVU / REMU sequencer for RV32 M-ops.
// It owns no adder. While busy it drives the shared core ALU through
// alu_src_a, alu_src_b and alu_operation, and it consumes alu_result in the same cycle.
// MUL is shift-and-add. DIVU/REMU use restoring division, MSB first.
// Optional feature: define MULDIV_EARLY_EXIT_EN to let MUL stop once the remaining
// multiplier is zero. It is off by default, which gives a fixed latency.
module alu_muldiv_seq #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [1:0]               op,
    input  logic [DATA_WIDTH-1:0]    operand_a,
    input  logic [DATA_WIDTH-1:0]    operand_b,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    result,
    output logic [DATA_WIDTH-1:0]    alu_src_a,
    output logic [DATA_WIDTH-1:0]    alu_src_b,
    output logic [OPCODE_LENGTH-1:0] alu_operation,
    input  logic [DATA_WIDTH-1:0]    alu_result
);

    localparam int CW = $clog2(DATA_WIDTH);

    localparam logic [OPCODE_LENGTH-1:0] ALU_ADD = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] ALU_SUB = OPCODE_LENGTH'(4'b0110);

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REMU = 2'b10;
    localparam logic [1:0] OP_RSV  = 2'b11;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                state_q, state_d;
    logic [1:0]            op_q, op_d;
    // The three working registers have different roles for each operation.
    // acc_q holds the product accumulator for MUL and the partial remainder for DIV.
    // ra_q holds the shifting multiplicand for MUL. For DIV it starts as the dividend,
    // and quotient bits shift in from the right as dividend bits leave on the left.
    // rb_q holds the shifting multiplier for MUL and the fixed divisor for DIV.
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] ra_q, ra_d;
    logic [DATA_WIDTH-1:0] rb_q, rb_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  last_iter;

    // Partial remainder extended by the next dividend bit.
    // The comparison is one bit wider than the data, so a remainder with its MSB set
    // still compares correctly.
    logic [DATA_WIDTH:0]   r33;
    logic                  div_ge;

    assign r33    = {acc_q, ra_q[DATA_WIDTH-1]};
    assign div_ge = (r33 >= {1'b0, rb_q});

    assign busy   = (state_q == StRun);
    assign done   = (state_q == StDone);
    assign result = result_q;

    // Drive the shared ALU only while iterating; it sees zeros otherwise.
    always_comb begin
        alu_src_a     = '0;
        alu_src_b     = '0;
        alu_operation = '0;
        if (state_q == StRun) begin
            if (op_q == OP_MUL) begin
                alu_src_a     = acc_q;
                alu_src_b     = ra_q;
                alu_operation = ALU_ADD;
            end else begin
                // SUB is issued even when r33 < divisor; that result is simply not used.
                alu_src_a     = r33[DATA_WIDTH-1:0];
                alu_src_b     = rb_q;
                alu_operation = ALU_SUB;
            end
        end
    end

    // Next-state logic: accept requests, iterate, and capture the result on the last step.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        acc_d     = acc_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        count_d   = count_q;
        result_d  = result_q;
        last_iter = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                // DONE lasts exactly one cycle, but it accepts a new request like IDLE does.
                state_d = StIdle;
                if (start) begin
                    op_d    = op;
                    acc_d   = '0;
                    ra_d    = operand_a;
                    rb_d    = operand_b;
                    count_d = '0;
                    state_d = StRun;
                    if (op == OP_RSV) begin
                        state_d  = StDone;
                        result_d = '0;
                    end else if ((op != OP_MUL) && (operand_b == '0)) begin
                        state_d  = StDone;
                        result_d = (op == OP_DIVU) ? '1 : operand_a;
                    end
`ifdef MULDIV_EARLY_EXIT_EN
                    else if ((op == OP_MUL) && (operand_b == '0)) begin
                        state_d  = StDone;
                        result_d = '0;
                    end
`endif
                end
            end
            StRun: begin
                count_d = count_q + 1'b1;
                if (op_q == OP_MUL) begin
                    if (rb_q[0]) begin
                        acc_d = alu_result;
                    end
                    ra_d = ra_q << 1;
                    rb_d = rb_q >> 1;
`ifdef MULDIV_EARLY_EXIT_EN
                    // Stop once no set multiplier bits remain for later iterations.
                    last_iter = (count_q == CW'(DATA_WIDTH - 1)) ||
                                (rb_q[DATA_WIDTH-1:1] == '0);
`else
                    last_iter = (count_q == CW'(DATA_WIDTH - 1));
`endif
                    if (last_iter) begin
                        result_d = acc_d;
                    end
                end else begin
                    acc_d     = div_ge ? alu_result : r33[DATA_WIDTH-1:0];
                    ra_d      = {ra_q[DATA_WIDTH-2:0], div_ge};
                    last_iter = (count_q == CW'(DATA_WIDTH - 1));
                    if (last_iter) begin
                        result_d = (op_q == OP_DIVU) ? ra_d : acc_d;
                    end
                end
                if (last_iter) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers. Reset is asynchronous and discards any partial work.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= '0;
            acc_q    <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq.
// It models the shared ALU, queues a reference-model result per request,
// and pops that result when done pulses. It also checks latency and ALU-port usage.
`timescale 1ns/1ps
module tb_alu_muldiv_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] operand_a = '0;
    logic [W-1:0] operand_b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] alu_src_a;
    logic [W-1:0] alu_src_b;
    logic [3:0]   alu_operation;
    logic [W-1:0] alu_result;

    int           vectors = 0;
    int           miscompares = 0;
    logic [W-1:0] sb_q[$];
    logic [W-1:0] sb_exp;
    logic [1:0]   cur_op = 2'b00;
    int           lat;

    alu_muldiv_seq #(
        .DATA_WIDTH   (W),
        .OPCODE_LENGTH(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op           (op),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_operation(alu_operation),
        .alu_result   (alu_result)
    );

    always #5 clk = ~clk;

    // Shared core ALU model
    always_comb begin
        case (alu_operation)
            4'b0010: alu_result = alu_src_a + alu_src_b;
            4'b0110: alu_result = alu_src_a - alu_src_b;
            default: alu_result = '0;
        endcase
    end

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (o)
            2'b00:   return a * b;
            2'b01:   return (b == '0) ? '1 : a / b;
            2'b10:   return (b == '0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] b);
        if (o == 2'b11) return 1;
        if ((o != 2'b00) && (b == '0)) return 1;
`ifdef MULDIV_EARLY_EXIT_EN
        if (o == 2'b00) begin
            if (b == '0) return 1;
            for (int i = W - 1; i >= 0; i--) begin
                if (b[i]) return i + 2;
            end
        end
`endif
        return W + 1;
    endfunction

    // Called at a negedge; the request is sampled at the following posedge.
    task automatic drive(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op        = o;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        cur_op    = o;
        sb_q.push_back(model(o, a, b));
    endtask

    // Count negedges until done. Returns at the negedge where done is seen.
    task automatic wait_done(input string tag, input int exp_l);
        int   l = 0;
        logic seen_busy = 1'b0;
        do begin
            @(negedge clk);
            l++;
            start = 1'b0;
            if (busy) seen_busy = 1'b1;
        end while (!done && l < 200);
        check_val({tag, "_lat"}, W'(l), W'(exp_l));
        if (exp_l == 1) check_val({tag, "_busy"}, W'(seen_busy), '0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        drive(o, a, b);
        wait_done(tag, exp_lat(o, b));
    endtask

    // Scoreboard pop and ALU-port usage checks
    always @(negedge clk) begin
        if (busy) begin
            check_val("alu_op_run", W'(alu_operation), (cur_op == 2'b00) ? W'(4'b0010) : W'(4'b0110));
        end else begin
            check_val("alu_idle_zero", alu_src_a | alu_src_b | W'(alu_operation), '0);
        end
        if (done) begin
            check_val("busy_with_done", W'(busy), '0);
            check_val("sb_nonempty", W'(sb_q.size() != 0), W'(1));
            if (sb_q.size() != 0) begin
                sb_exp = sb_q.pop_front();
                check_val("result", result, sb_exp);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;

        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_busy", W'(busy), '0);
        check_val("rst_done", W'(done), '0);
        check_val("rst_result", result, '0);
        check_val("rst_alu", alu_src_a | alu_src_b | W'(alu_operation), '0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_op("mul_7x6", 2'b00, 32'd7, 32'd6);
        repeat (2) @(negedge clk);
        run_op("mul_ffxff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        // Issued in the DONE cycle of the previous op
        run_op("b2b_divu", 2'b01, 32'd100, 32'd7);
        repeat (1) @(negedge clk);
        run_op("remu_100_7", 2'b10, 32'd100, 32'd7);
        run_op("divu_big", 2'b01, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("remu_big", 2'b10, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("divu_33b", 2'b01, 32'hFFFF_FFFE, 32'h8000_0001);
        run_op("remu_33b", 2'b10, 32'hFFFF_FFFE, 32'h8000_0001);
        repeat (2) @(negedge clk);
        run_op("divu_by0", 2'b01, 32'd5, 32'd0);
        run_op("remu_by0", 2'b10, 32'd5, 32'd0);
        run_op("rsv_op", 2'b11, 32'd9, 32'd3);
        run_op("mul_by0", 2'b00, 32'h1234_5678, 32'd0);
        run_op("mul_by1", 2'b00, 32'h1234_5678, 32'd1);

        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 2));
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run_op("rand", ro, ra, rb);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // A second start while busy must be ignored
        repeat (2) @(negedge clk);
        drive(2'b00, 32'd12345, 32'h8000_0003);
        lat = 0;
        repeat (10) begin
            @(negedge clk);
            lat++;
            start = 1'b0;
        end
        op        = 2'b01;
        operand_a = 32'd1000;
        operand_b = 32'd3;
        start     = 1'b1;
        @(negedge clk);
        lat++;
        start = 1'b0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check_val("ignore_lat", W'(lat), W'(W + 1));
        repeat (3) @(negedge clk);
        check_val("ignore_no_2nd_done", W'(done), '0);

        // Asynchronous reset in the middle of an operation
        run_op("pre_rst", 2'b00, 32'd3, 32'd5);
        repeat (2) @(negedge clk);
        drive(2'b00, 32'hDEAD, 32'h8000_0001);
        repeat (15) begin
            @(negedge clk);
            start = 1'b0;
        end
        check_val("mid_busy", W'(busy), W'(1));
        #2 reset = 1'b1;
        #1;
        check_val("arst_busy", W'(busy), '0);
        check_val("arst_done", W'(done), '0);
        check_val("arst_result", result, '0);
        check_val("arst_alu", alu_src_a | alu_src_b | W'(alu_operation), '0);
        // That request was abandoned, so no result is expected for it
        if (sb_q.size() != 0) sb_exp = sb_q.pop_back();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        run_op("post_rst", 2'b01, 32'd81, 32'd9);

        repeat (3) @(negedge clk);
        check_val("sb_drain", W'(sb_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
